mem_access_unit: RTL and testbench

MEM-stage consumer of the EXE/MEM pipeline register outputs. Decodes the registered memory controls, runs a req/ack transaction to the data-memory port for loads and stores, stalls the upstream pipeline while a transaction is outstanding, and drives the MEM/WB pipeline register (write-back data, destination register, write enable). Non-memory instructions pass through with one-cycle latency and no stall.

---
 rtl/mem_access_unit.sv | 155 +++++++++++++++
 tb/tb_mem_access_unit.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// mem_access_unit: MEM-stage memory access unit.
// Consumes the EXE/MEM register outputs, runs a req/ack transaction on the
// data-memory port for loads and stores, stalls upstream while a transaction
// is outstanding, and drives the MEM/WB pipeline register.
//
// Ports:
//   clk, clrn                 clock (rising edge), async active-low reset
//   mem_result, mem_rb        ALU result (address / wb value), store data
//   mem_wmem, mem_m2reg       store / load request
//   mem_wreg, mem_rn          register write enable, destination register
//   dm_req, dm_we             memory request and write strobe (registered)
//   dm_addr, dm_wdata         memory address and store data (registered)
//   dm_rdata, dm_ack          load data and transaction-complete from memory
//   mem_stall                 combinational hold for EXE/MEM and earlier stages
//   wb_data, wb_rn, wb_wreg   MEM/WB register outputs
//   mem_err                   sticky timeout flag
module mem_access_unit #(
   parameter int unsigned MAX_WAIT = 15
) (
   input  logic        clk,
   input  logic        clrn,
   input  logic [31:0] mem_result,
   input  logic [31:0] mem_rb,
   input  logic        mem_wmem,
   input  logic        mem_m2reg,
   input  logic        mem_wreg,
   input  logic [4:0]  mem_rn,
   output logic        dm_req,
   output logic        dm_we,
   output logic [31:0] dm_addr,
   output logic [31:0] dm_wdata,
   input  logic [31:0] dm_rdata,
   input  logic        dm_ack,
   output logic        mem_stall,
   output logic [31:0] wb_data,
   output logic [4:0]  wb_rn,
   output logic        wb_wreg,
   output logic        mem_err
);

   localparam int unsigned DW = 32;
   localparam int unsigned RW = 5;
   localparam int unsigned CW = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t        state, state_nxt;
   logic [DW-1:0] rbuf, rbuf_nxt;
   logic [CW-1:0] wcnt, wcnt_nxt;
   logic          dm_req_nxt, dm_we_nxt;
   logic [DW-1:0] dm_addr_nxt, dm_wdata_nxt;
   logic [DW-1:0] wb_data_nxt;
   logic [RW-1:0] wb_rn_nxt;
   logic          wb_wreg_nxt, mem_err_nxt;
   logic          access;

   assign access = mem_wmem | mem_m2reg;

   // State and registered outputs
   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) begin
         state    <= IDLE;
         rbuf     <= '0;
         wcnt     <= '0;
         dm_req   <= 1'b0;
         dm_we    <= 1'b0;
         dm_addr  <= '0;
         dm_wdata <= '0;
         wb_data  <= '0;
         wb_rn    <= '0;
         wb_wreg  <= 1'b0;
         mem_err  <= 1'b0;
      end else begin
         state    <= state_nxt;
         rbuf     <= rbuf_nxt;
         wcnt     <= wcnt_nxt;
         dm_req   <= dm_req_nxt;
         dm_we    <= dm_we_nxt;
         dm_addr  <= dm_addr_nxt;
         dm_wdata <= dm_wdata_nxt;
         wb_data  <= wb_data_nxt;
         wb_rn    <= wb_rn_nxt;
         wb_wreg  <= wb_wreg_nxt;
         mem_err  <= mem_err_nxt;
      end
   end

   // Next-state, next-register values and the combinational stall
   always_comb begin
      state_nxt    = state;
      rbuf_nxt     = rbuf;
      wcnt_nxt     = wcnt;
      dm_req_nxt   = dm_req;
      dm_we_nxt    = dm_we;
      dm_addr_nxt  = dm_addr;
      dm_wdata_nxt = dm_wdata;
      wb_data_nxt  = wb_data;
      wb_rn_nxt    = wb_rn;
      wb_wreg_nxt  = wb_wreg;
      mem_err_nxt  = mem_err;
      mem_stall    = 1'b0;

      unique case (state)
         IDLE: begin
            if (access) begin
               mem_stall    = 1'b1;
               dm_req_nxt   = 1'b1;
               dm_we_nxt    = mem_wmem;
               dm_addr_nxt  = mem_result;
               dm_wdata_nxt = mem_rb;
               wcnt_nxt     = '0;
               state_nxt    = BUSY;
            end else begin
               wb_data_nxt = mem_result;
               wb_rn_nxt   = mem_rn;
               wb_wreg_nxt = mem_wreg;
            end
         end

         BUSY: begin
            mem_stall = 1'b1;
            if (dm_ack) begin
               // dm_we is the latched store/load decision for this transaction
               dm_req_nxt = 1'b0;
               rbuf_nxt   = dm_we ? mem_result : dm_rdata;
               state_nxt  = DONE;
            end else if (wcnt == CW'(MAX_WAIT - 1)) begin
               dm_req_nxt  = 1'b0;
               rbuf_nxt    = '0;
               mem_err_nxt = 1'b1;
               state_nxt   = DONE;
            end else begin
               wcnt_nxt = wcnt + CW'(1);
            end
         end

         DONE: begin
            // Upstream advances on this edge, so WB loads exactly once per op
            wb_data_nxt = rbuf;
            wb_rn_nxt   = mem_rn;
            wb_wreg_nxt = mem_wreg & ~mem_wmem;
            state_nxt   = IDLE;
         end

         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_mem_access_unit.sv
// Testbench for mem_access_unit: directed plus randomized instruction stream,
// checked against a per-instruction behavioural model of latency and results.
module tb_mem_access_unit;

   localparam int unsigned MW = 4;

   logic        clk = 1'b0;
   logic        clrn;
   logic [31:0] mem_result, mem_rb;
   logic        mem_wmem, mem_m2reg, mem_wreg;
   logic [4:0]  mem_rn;
   logic        dm_req, dm_we;
   logic [31:0] dm_addr, dm_wdata;
   logic [31:0] dm_rdata;
   logic        dm_ack;
   logic        mem_stall;
   logic [31:0] wb_data;
   logic [4:0]  wb_rn;
   logic        wb_wreg;
   logic        mem_err;

   int total = 0;
   int bad   = 0;

   // Model state: MEM/WB contents and sticky error expected after last op
   logic [31:0] exp_wb_data;
   logic [4:0]  exp_wb_rn;
   logic        exp_wb_wreg;
   logic        exp_err;

   mem_access_unit #(.MAX_WAIT(MW)) dut (
      .clk       (clk),
      .clrn      (clrn),
      .mem_result(mem_result),
      .mem_rb    (mem_rb),
      .mem_wmem  (mem_wmem),
      .mem_m2reg (mem_m2reg),
      .mem_wreg  (mem_wreg),
      .mem_rn    (mem_rn),
      .dm_req    (dm_req),
      .dm_we     (dm_we),
      .dm_addr   (dm_addr),
      .dm_wdata  (dm_wdata),
      .dm_rdata  (dm_rdata),
      .dm_ack    (dm_ack),
      .mem_stall (mem_stall),
      .wb_data   (wb_data),
      .wb_rn     (wb_rn),
      .wb_wreg   (wb_wreg),
      .mem_err   (mem_err)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      total++;
      assert (obs === exp_v)
      else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
      end
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_dm_req"},   32'(dm_req),   32'd0);
      check({tag, "_dm_we"},    32'(dm_we),    32'd0);
      check({tag, "_dm_addr"},  dm_addr,       32'd0);
      check({tag, "_dm_wdata"}, dm_wdata,      32'd0);
      check({tag, "_wb_data"},  wb_data,       32'd0);
      check({tag, "_wb_rn"},    32'(wb_rn),    32'd0);
      check({tag, "_wb_wreg"},  32'(wb_wreg),  32'd0);
      check({tag, "_mem_err"},  32'(mem_err),  32'd0);
      check({tag, "_stall"},    32'(mem_stall), 32'd0);
   endtask

   // One instruction through MEM. Called just after a falling edge.
   // ack_k: BUSY cycle (1-based) in which memory acks; 0 = never.
   task automatic run_instr(input string tag,
                            input logic wmem, input logic m2reg, input logic wreg,
                            input logic [4:0] rn, input logic [31:0] result,
                            input logic [31:0] rb, input int ack_k,
                            input logic [31:0] rdata);
      bit          access;
      bit          acked;
      int          e_reqs, e_stalls;
      logic [31:0] e_data;
      int          reqs, stalls, cyc;
      bit          done;
      bit          seen_req;

      access = wmem | m2reg;
      acked  = access && ack_k >= 1 && ack_k <= int'(MW);
      if (!access) begin
         e_reqs = 0; e_stalls = 0; e_data = result;
      end else if (acked) begin
         e_reqs = ack_k; e_stalls = ack_k + 1; e_data = wmem ? result : rdata;
      end else begin
         e_reqs = int'(MW); e_stalls = int'(MW) + 1; e_data = 32'd0;
      end

      mem_wmem = wmem; mem_m2reg = m2reg; mem_wreg = wreg;
      mem_rn = rn; mem_result = result; mem_rb = rb;
      #1;
      // Every op starts in IDLE: no request outstanding (the gap between ops)
      check({tag, "_first_req"},   32'(dm_req),    32'd0);
      check({tag, "_first_stall"}, 32'(mem_stall), 32'(access));

      reqs = 0; stalls = 0; cyc = 0; done = 0; seen_req = 0;
      while (!done && cyc < 64) begin
         if (dm_req) begin
            reqs++;
            if (!seen_req) begin
               seen_req = 1;
               check({tag, "_dm_we"},    32'(dm_we), 32'(wmem));
               check({tag, "_dm_addr"},  dm_addr,    result);
               check({tag, "_dm_wdata"}, dm_wdata,   rb);
            end
            dm_ack   = (reqs == ack_k);
            dm_rdata = dm_ack ? rdata : $urandom;
         end else begin
            // Stray acks outside BUSY must be ignored
            dm_ack   = 1'($urandom_range(0, 1));
            dm_rdata = $urandom;
         end
         if (mem_stall) begin
            stalls++;
            if (stalls == 1) begin
               check({tag, "_hold_data"}, wb_data,       exp_wb_data);
               check({tag, "_hold_wreg"}, 32'(wb_wreg),  32'(exp_wb_wreg));
            end
         end else begin
            done = 1;
         end
         cyc++;
         @(negedge clk);
         #1;
      end
      dm_ack = 1'b0;

      exp_wb_data = e_data;
      exp_wb_rn   = rn;
      exp_wb_wreg = wreg & ~wmem;
      if (access && !acked) exp_err = 1'b1;

      check({tag, "_reqs"},    32'(reqs),    32'(e_reqs));
      check({tag, "_stalls"},  32'(stalls),  32'(e_stalls));
      check({tag, "_wb_data"}, wb_data,      exp_wb_data);
      check({tag, "_wb_rn"},   32'(wb_rn),   32'(exp_wb_rn));
      check({tag, "_wb_wreg"}, 32'(wb_wreg), 32'(exp_wb_wreg));
      check({tag, "_mem_err"}, 32'(mem_err), 32'(exp_err));
   endtask

   initial begin
      clrn = 1'b0;
      mem_result = '0; mem_rb = '0; mem_wmem = 1'b0; mem_m2reg = 1'b0;
      mem_wreg = 1'b0; mem_rn = '0; dm_rdata = '0; dm_ack = 1'b0;
      exp_wb_data = '0; exp_wb_rn = '0; exp_wb_wreg = 1'b0; exp_err = 1'b0;

      // Power-on reset
      #12;
      check_all_zero("por");
      @(negedge clk);
      clrn = 1'b1;
      #1;

      // Directed operations
      run_instr("alu0",   0, 0, 1, 5'd1,  32'hA5A5_0001, 32'h0, 0, 32'h0);
      run_instr("load1",  0, 1, 1, 5'd8,  32'h0000_0100, 32'h0, 1, 32'hDEAD_BEEF);
      run_instr("store3", 1, 0, 1, 5'd5,  32'h0000_0040, 32'h1234_5678, 3, 32'h0);
      run_instr("ldlast", 0, 1, 1, 5'd9,  32'h0000_0200, 32'h0, int'(MW), 32'hCAFE_F00D);
      check("ldlast_noerr", 32'(mem_err), 32'd0);
      run_instr("ldto",   0, 1, 1, 5'd10, 32'h0000_0300, 32'h0, 0, 32'h0);
      run_instr("alu_err",0, 0, 1, 5'd11, 32'h0000_0777, 32'h0, 0, 32'h0);

      // Back-to-back load, ALU op, store
      run_instr("b2b_ld", 0, 1, 1, 5'd12, 32'h0000_0400, 32'h0, 2, 32'h1111_2222);
      run_instr("b2b_alu",0, 0, 1, 5'd13, 32'h0000_0099, 32'h0, 0, 32'h0);
      run_instr("b2b_st", 1, 0, 0, 5'd14, 32'h0000_0404, 32'h3333_4444, 1, 32'h0);

      // Both wmem and m2reg: store wins, no write-back
      run_instr("both",   1, 1, 1, 5'd15, 32'h0000_0500, 32'hABCD_EF01, 2, 32'h5555_6666);

      // Randomized instruction stream
      for (int i = 0; i < 40; i++) begin
         int          kind;
         int          k;
         kind = int'($urandom_range(0, 3));
         k    = int'($urandom_range(0, MW + 1));
         if (k == 0 && $urandom_range(0, 3) != 0) k = 1;
         run_instr($sformatf("rnd%0d", i),
                   kind == 2 || kind == 3, kind == 1 || kind == 3,
                   1'($urandom_range(0, 1)), 5'($urandom), $urandom, $urandom,
                   k, $urandom);
      end

      // Reset in the middle of a transaction
      mem_wmem = 1'b0; mem_m2reg = 1'b1; mem_wreg = 1'b1;
      mem_rn = 5'd20; mem_result = 32'h0000_0800; mem_rb = '0;
      dm_ack = 1'b0;
      @(negedge clk);
      @(negedge clk);
      #1;
      check("midbusy_req", 32'(dm_req), 32'd1);
      mem_m2reg = 1'b0;
      clrn = 1'b0;
      #1;
      check_all_zero("rst_mid");
      exp_wb_data = '0; exp_wb_rn = '0; exp_wb_wreg = 1'b0; exp_err = 1'b0;
      @(negedge clk);
      clrn = 1'b1;
      #1;
      run_instr("post_rst", 0, 0, 1, 5'd3, 32'h0000_0055, 32'h0, 0, 32'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
